// File: rtl/inst_sram_like_responder_pkg.sv
// Shared encodings and defaults for the SRAM-like bus responder.
// Imported by the top level and by the response queue.
package inst_sram_like_responder_pkg;

   localparam int DATA_W              = 32;
   localparam int TIMER_W             = 4;
   localparam int DEPTH_LOG2_DEF      = 12;
   localparam int MAX_OUTSTANDING_DEF = 2;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order response FIFO of {data, timer}.
// Every stored timer counts down each cycle and stops at zero.
module sram_like_resp_queue
   import inst_sram_like_responder_pkg::*;
#(
   parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         push,
   input  logic [DATA_W-1:0]            push_data,
   input  logic [TIMER_W-1:0]           push_timer,
   input  logic                         pop,
   output logic                         head_ready,
   output logic [DATA_W-1:0]            head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0]  data_r  [DEPTH];
   logic [TIMER_W-1:0] timer_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Storage, pointers, occupancy and parallel timer countdown.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            data_r[i]  <= {DATA_W{1'b0}};
            timer_r[i] <= {TIMER_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (timer_r[i] != {TIMER_W{1'b0}}) begin
               timer_r[i] <= timer_r[i] - TIMER_W'(1);
            end
         end
         if (push) begin
            data_r[wr_ptr_r]  <= push_data;
            timer_r[wr_ptr_r] <= push_timer;
            wr_ptr_r          <= ptr_next(wr_ptr_r);
         end
         if (pop) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_ready = (count_r != {CNT_W{1'b0}}) && (timer_r[rd_ptr_r] == {TIMER_W{1'b0}});
   assign head_data  = data_r[rd_ptr_r];
   assign count      = count_r;

endmodule

// File: rtl/inst_sram_like_responder.sv
// Slave end of the SRAM-like bus: accepts requests, drives a 1-cycle RAM,
// and returns in-order responses after a per-request programmable wait.
module inst_sram_like_responder
   import inst_sram_like_responder_pkg::*;
#(
   parameter int DEPTH_LOG2      = DEPTH_LOG2_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req,
   input  logic                  wr,
   input  logic [1:0]            size,
   input  logic [3:0]            wstrb,
   input  logic [31:0]           addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic                  addr_ok,
   output logic                  data_ok,
   output logic [DATA_W-1:0]     rdata,
   input  logic [TIMER_W-1:0]    cfg_delay,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [DEPTH_LOG2-1:0] ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic               accept_s;
   logic [CNT_W-1:0]   q_count_s;
   logic [CNT_W-1:0]   count_s;
   logic               head_ready_s;
   logic [DATA_W-1:0]  head_data_s;
   logic [DATA_W-1:0]  push_data_s;
   logic               pend_valid_r;
   logic               pend_wr_r;
   logic [TIMER_W-1:0] pend_delay_r;
   logic               unused_s;

   // The RAM-cycle entry counts as outstanding so the queue can never overflow.
   assign count_s  = q_count_s + CNT_W'(pend_valid_r);
   assign addr_ok  = resetn && (count_s < CNT_W'(MAX_OUTSTANDING));
   assign accept_s = req && addr_ok;

   assign ram_en    = accept_s;
   assign ram_we    = (accept_s && wr) ? wstrb : 4'b0000;
   assign ram_addr  = addr[DEPTH_LOG2+1:2];
   assign ram_wdata = wdata;

   // Remembers the request sitting in the RAM cycle until its data returns.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_valid_r <= 1'b0;
         pend_wr_r    <= 1'b0;
         pend_delay_r <= {TIMER_W{1'b0}};
      end else begin
         pend_valid_r <= accept_s;
         pend_wr_r    <= wr;
         pend_delay_r <= cfg_delay;
      end
   end

   assign push_data_s = pend_wr_r ? {DATA_W{1'b0}} : ram_rdata;

   sram_like_resp_queue #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_queue (
      .clk        (clk),
      .resetn     (resetn),
      .push       (pend_valid_r),
      .push_data  (push_data_s),
      .push_timer (pend_delay_r),
      .pop        (head_ready_s),
      .head_ready (head_ready_s),
      .head_data  (head_data_s),
      .count      (q_count_s)
   );

   assign data_ok = head_ready_s;
   assign rdata   = head_ready_s ? head_data_s : {DATA_W{1'b0}};

   // Size is informational and the upper/lower address bits are ignored.
   assign unused_s = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

endmodule

// File: tb/tb_inst_sram_like_responder.sv
// Directed bench for inst_sram_like_responder with a byte-enabled
// synchronous RAM model and a data_ok monitor logging response cycles.
module tb_inst_sram_like_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [3:0]  cfg_delay = 4'd0;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;

   logic [31:0] mem [0:4095];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          rc[$];
   logic [31:0] rd[$];

   inst_sram_like_responder dut (
      .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .cfg_delay(cfg_delay), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-first synchronous RAM with byte write enables.
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (data_ok) begin
         rc.push_back(cyc);
         rd.push_back(rdata);
      end
   end

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] dl,
                        output int t_acc, output int stalls,
                        output logic en_seen, output logic [3:0] we_seen, output logic [11:0] ad_seen);
      req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; cfg_delay = dl;
      t_acc = -1; stalls = 0; en_seen = 1'b0; we_seen = 4'h0; ad_seen = 12'h0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (addr_ok) begin
            t_acc = cyc; en_seen = ram_en; we_seen = ram_we; ad_seen = ram_addr;
            @(negedge clk);
            break;
         end
         stalls++;
         @(negedge clk);
         #1;
      end
      req = 1'b0; wr = 1'b0; wstrb = 4'h0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; req = 1'b1; wr = 1'b1; wstrb = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL reset_addr_ok: got %0b want 0", addr_ok); end
      total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok: got %0b want 0", data_ok); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %08h want 0", rdata); end
      total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en: got %0b want 0", ram_en); end
      total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL reset_ram_we: got %0h want 0", ram_we); end
      req = 1'b0; wr = 1'b0; wstrb = 4'h0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL reset_release_addr_ok: got %0b want 1", addr_ok); end
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int tw, tr, st; logic en; logic [3:0] we; logic [11:0] ad;
      rc.delete(); rd.delete();
      issue(1'b1, 32'h1C000000, 32'hDEADBEEF, 4'hF, 4'd0, tw, st, en, we, ad);
      total++; if (en !== 1'b1 || we !== 4'hF || ad !== 12'h000) begin bad++; $display("FAIL wr_ram_drive: got en=%0b we=%0h addr=%0h want 1 F 0", en, we, ad); end
      issue(1'b0, 32'h1C000000, 32'h0, 4'h0, 4'd0, tr, st, en, we, ad);
      total++; if (tr !== tw + 1) begin bad++; $display("FAIL wr_rd_accept: got %0d want %0d", tr, tw + 1); end
      repeat (8) @(negedge clk);
      total++;
      if (rc.size() != 2) begin bad++; $display("FAIL wr_rd_count: got %0d want 2", rc.size()); end
      else if (rc[0] != tw + 2 || rd[0] !== 32'h0 || rc[1] != tr + 2 || rd[1] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL wr_rd_resp: got %0d:%08h %0d:%08h want %0d:0 %0d:deadbeef", rc[0], rd[0], rc[1], rd[1], tw + 2, tr + 2);
      end
   endtask

   task automatic test_three_reads();
      int ta, tb2, tc, sa, sb, sc; logic en; logic [3:0] we; logic [11:0] ad;
      mem[1] = 32'h11111111; mem[2] = 32'h22222222; mem[3] = 32'h33333333;
      rc.delete(); rd.delete();
      issue(1'b0, 32'h4, 32'h0, 4'h0, 4'd0, ta, sa, en, we, ad);
      issue(1'b0, 32'h8, 32'h0, 4'h0, 4'd0, tb2, sb, en, we, ad);
      issue(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, tc, sc, en, we, ad);
      total++; if (tb2 !== ta + 1 || sb != 0) begin bad++; $display("FAIL three_second: got %0d stalls=%0d want %0d stalls=0", tb2, sb, ta + 1); end
      total++; if (tc !== ta + 3 || sc != 1) begin bad++; $display("FAIL three_third: got %0d stalls=%0d want %0d stalls=1", tc, sc, ta + 3); end
      repeat (8) @(negedge clk);
      total++;
      if (rc.size() != 3) begin bad++; $display("FAIL three_count: got %0d want 3", rc.size()); end
      else if (rc[0] != ta + 2 || rc[1] != ta + 3 || rc[2] != ta + 5) begin
         bad++; $display("FAIL three_cycles: got %0d %0d %0d want %0d %0d %0d", rc[0], rc[1], rc[2], ta + 2, ta + 3, ta + 5);
      end
      total++;
      if (rc.size() == 3 && (rd[0] !== 32'h11111111 || rd[1] !== 32'h22222222 || rd[2] !== 32'h33333333)) begin
         bad++; $display("FAIL three_data: got %08h %08h %08h want 11111111 22222222 33333333", rd[0], rd[1], rd[2]);
      end
   endtask

   task automatic test_delay();
      int t1, t2, st; logic en; logic [3:0] we; logic [11:0] ad;
      mem[4] = 32'h44444444; mem[6] = 32'h66666666;
      rc.delete(); rd.delete();
      issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd3, t1, st, en, we, ad);
      issue(1'b0, 32'h18, 32'h0, 4'h0, 4'd0, t2, st, en, we, ad);
      repeat (12) @(negedge clk);
      total++;
      if (rc.size() != 2) begin bad++; $display("FAIL delay_count: got %0d want 2", rc.size()); end
      else if (rc[0] != t1 + 5 || rc[1] != t1 + 6 || rd[0] !== 32'h44444444 || rd[1] !== 32'h66666666) begin
         bad++; $display("FAIL delay_resp: got %0d:%08h %0d:%08h want %0d:44444444 %0d:66666666", rc[0], rd[0], rc[1], rd[1], t1 + 5, t1 + 6);
      end
   endtask

   task automatic test_partial_write();
      int tw, tr, st; logic en; logic [3:0] we; logic [11:0] ad;
      mem[5] = 32'h11223344;
      rc.delete(); rd.delete();
      issue(1'b1, 32'h14, 32'h0000AB00, 4'b0010, 4'd0, tw, st, en, we, ad);
      total++; if (we !== 4'b0010 || ad !== 12'h005) begin bad++; $display("FAIL pw_ram_drive: got we=%0h addr=%0h want 2 5", we, ad); end
      issue(1'b0, 32'h14, 32'h0, 4'h0, 4'd0, tr, st, en, we, ad);
      repeat (8) @(negedge clk);
      total++;
      if (rc.size() != 2) begin bad++; $display("FAIL pw_count: got %0d want 2", rc.size()); end
      else if (rd[0] !== 32'h0 || rd[1] !== 32'h1122AB44) begin
         bad++; $display("FAIL pw_data: got %08h %08h want 00000000 1122ab44", rd[0], rd[1]);
      end
   endtask

   task automatic test_accept_retire();
      int t[5]; int s[5]; int exp_t[5]; int exp_s[5]; int exp_r[5];
      logic en; logic [3:0] we; logic [11:0] ad;
      exp_t = '{0, 1, 3, 4, 6}; exp_s = '{0, 0, 1, 0, 1}; exp_r = '{2, 3, 5, 6, 8};
      for (int i = 0; i < 5; i++) mem[8 + i] = 32'hA0000000 + 32'(i);
      rc.delete(); rd.delete();
      for (int i = 0; i < 5; i++) issue(1'b0, 32'(32 + 4 * i), 32'h0, 4'h0, 4'd0, t[i], s[i], en, we, ad);
      for (int i = 1; i < 5; i++) begin
         total++;
         if (t[i] != t[0] + exp_t[i] || s[i] != exp_s[i]) begin
            bad++; $display("FAIL ar_accept%0d: got +%0d stalls=%0d want +%0d stalls=%0d", i, t[i] - t[0], s[i], exp_t[i], exp_s[i]);
         end
      end
      repeat (8) @(negedge clk);
      total++;
      if (rc.size() != 5) begin bad++; $display("FAIL ar_count: got %0d want 5", rc.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (rc[i] != t[0] + exp_r[i] || rd[i] !== 32'hA0000000 + 32'(i)) begin
               bad++; $display("FAIL ar_resp%0d: got +%0d:%08h want +%0d:%08h", i, rc[i] - t[0], rd[i], exp_r[i], 32'hA0000000 + 32'(i));
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      int t1, t2, t3, st; logic en; logic [3:0] we; logic [11:0] ad;
      rc.delete(); rd.delete();
      issue(1'b0, 32'h10, 32'h0, 4'h0, 4'd5, t1, st, en, we, ad);
      issue(1'b0, 32'h18, 32'h0, 4'h0, 4'd5, t2, st, en, we, ad);
      resetn = 1'b0; req = 1'b1;
      #1;
      total++; if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'h0 || ram_en !== 1'b0 || ram_we !== 4'h0) begin
         bad++; $display("FAIL rst_mid_outputs: got ok=%0b dok=%0b rdata=%08h en=%0b we=%0h want 0 0 0 0 0", addr_ok, data_ok, rdata, ram_en, ram_we);
      end
      req = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL rst_mid_addr_ok: got %0b want 1", addr_ok); end
      repeat (12) @(negedge clk);
      total++; if (rc.size() != 0) begin bad++; $display("FAIL rst_mid_stale: got %0d responses want 0", rc.size()); end
      rc.delete(); rd.delete();
      issue(1'b0, 32'h14, 32'h0, 4'h0, 4'd0, t3, st, en, we, ad);
      repeat (6) @(negedge clk);
      total++;
      if (rc.size() != 1) begin bad++; $display("FAIL rst_mid_new_count: got %0d want 1", rc.size()); end
      else if (rc[0] != t3 + 2 || rd[0] !== 32'h1122AB44) begin
         bad++; $display("FAIL rst_mid_new: got %0d:%08h want %0d:1122ab44", rc[0], rd[0], t3 + 2);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_three_reads();
      test_delay();
      test_partial_write();
      test_accept_retire();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_sram_like_responder.md
# inst_sram_like_responder

Slave end of the SRAM-like bus (req / addr_ok / data_ok) that the fetch and memory stages drive as initiators. It accepts up to MAX_OUTSTANDING requests, issues each to a synchronous single-port RAM, and returns responses strictly in order. A programmable per-request extra wait lets benches and FPGA bring-up exercise every pipeline stall path.

## Interface
- DEPTH_LOG2, 12: RAM depth in 32-bit words; word index = addr[DEPTH_LOG2+1:2].
- MAX_OUTSTANDING, 2: accepted-but-unanswered request limit (2..4).
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  request valid from initiator.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0: 1 B, 1: 2 B, 2: 4 B (informational; strobes carry byte enables).
- wstrb  in  4  write byte enables.
- addr  in  32  byte address.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  read data, valid with data_ok; 0 for write responses.
- cfg_delay  in  4  extra wait cycles, sampled per request at acceptance.
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  DEPTH_LOG2  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, 1-cycle latency after ram_en.

## Operation
- Accept = req && addr_ok. addr_ok = resetn && (count < MAX_OUTSTANDING). There is no same-cycle bypass on retire.
- On accept at cycle T: ram_en=1, ram_we = wr ? wstrb : 0, ram_addr = word index, ram_wdata = wdata. All are combinational from the request. Upper addr bits are ignored; misalignment is not checked.
- At T+1: ram_rdata (forced to 0 for writes) is captured into the response queue tail together with timer = cfg_delay sampled at T.
- The timers of all queued entries decrement every cycle, saturating at 0.
- data_ok = head valid && head timer == 0. rdata = head data. The head retires in the same cycle.
- Responses are strictly in acceptance order. There is no back-pressure on data_ok: the initiator must take every pulse.
- count = entries issued but not retired, including the in-flight RAM-cycle entry. On simultaneous accept and retire, count is unchanged.
- Write followed by read to the same address returns the new data. The RAM port is single-issue, so ordering is guaranteed.

## Timing
- Minimum latency is accept at T to data_ok at T+2 with cfg_delay=0. General case: data_ok at T+2+D, or later if the head of the queue is blocked.
- Back-to-back reads with D=0 sustain 1 response per cycle once the pipeline is full. With MAX_OUTSTANDING=2, throughput is 2 requests per 3 cycles.
- Reset values: addr_ok 0 (while resetn low), data_ok 0, rdata 0, ram_en 0, ram_we 0, count 0, queue empty.
- Reset mid-operation drops all outstanding entries. No data_ok is emitted for pre-reset requests. addr_ok returns high in the first cycle after deassertion.
- Full: addr_ok low until the cycle after a retire.
- Empty: data_ok low.
- Queue pointers wrap modulo MAX_OUTSTANDING.

## Structure
- Shared package holds: SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, DATA_W=32, and the default DEPTH_LOG2 / MAX_OUTSTANDING.
- One sub-module, sram_like_resp_queue, is an in-order FIFO of {data, timer} with parallel timer decrement, push/pop, and count. The top level holds accept logic, RAM drive, and the T+1 capture register.

## Test plan
- Write 0xDEADBEEF to addr 0x1C000000 (wstrb F), then read it with D=0 -> data_ok at T+2 with rdata 0xDEADBEEF; the write data_ok carries rdata 0.
- Issue three reads on consecutive cycles, D=0, MAX_OUTSTANDING=2 -> addr_ok low on the third request until the cycle after the first data_ok; the three responses arrive in order.
- Read with cfg_delay=3, then a read with cfg_delay=0 -> the second response waits behind the first; data_ok at T+5 and T+6.
- Partial write wstrb=4'b0010, data 0x0000AB00, over 0x11223344, then a read -> 0x1122AB44.
- Accept a read and retire the head in the same cycle while full -> count is unchanged and addr_ok follows the <MAX rule.
- Drop resetn with 2 outstanding requests -> no data_ok ever appears for them; all outputs take reset values; a new read after reset returns correctly.
